// File: rtl/maze_player_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maze_player_ctrl: button-driven player position and game-state controller.  |
// | Optional step counter enabled by macro MAZE_STEP_COUNT_EN.   Rev 1.0        |
// +----------------------------------------------------------------------------+
module maze_player_ctrl #(
  parameter int GRID_W  = 60,
  parameter int GRID_H  = 40,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 58,
  parameter int GOAL_Y  = 38
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Start,
  input  logic                       i_Up,
  input  logic                       i_Down,
  input  logic                       i_Left,
  input  logic                       i_Right,
  input  logic [GRID_W*GRID_H-1:0]   i_Maze,
  output logic [5:0]                 o_Player_X,
  output logic [5:0]                 o_Player_Y,
  output logic [1:0]                 o_MazeState,
  output logic                       o_Move_Done
`ifdef MAZE_STEP_COUNT_EN
  ,
  output logic [15:0]                o_Step_Count
`endif
);

  localparam int c_IDX_W     = $clog2(GRID_W*GRID_H);
  localparam int c_START_IDX = START_Y*GRID_W + START_X;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WON   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Button bit order: [4] Start, [3] Up, [2] Down, [1] Left, [0] Right
  logic [4:0] w_btn_raw;
  logic [4:0] sync1_q, sync2_q, prev_q, arm_q, edge_q;
  logic [1:0] fill_q;

  assign w_btn_raw = {i_Start, i_Up, i_Down, i_Left, i_Right};

  // A button is armed only after it has been seen low with valid sync data,
  // so one held through reset release cannot produce an edge.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      edge_q  <= '0;
      fill_q  <= '0;
    end else begin
      fill_q  <= {fill_q[0], 1'b1};
      sync1_q <= w_btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= arm_q | (~sync2_q & {5{fill_q[1]}});
      edge_q  <= sync2_q & ~prev_q & arm_q;
    end
  end

  state_t      state_q;
  logic [1:0]  maze_state_q;
  logic [5:0]  px_q, py_q;
  logic [5:0]  tx_q, ty_q;
  logic        toob_q;
  logic        done_q;
`ifdef MAZE_STEP_COUNT_EN
  logic [15:0] step_q;
`endif

  logic [5:0]  tgt_x_d, tgt_y_d;
  logic        tgt_oob_d;
  logic        w_dir_req;
  logic [c_IDX_W-1:0] w_idx;
  logic        w_blocked;

  assign w_dir_req = |edge_q[3:0];

  always_comb begin
    tgt_x_d   = px_q;
    tgt_y_d   = py_q;
    tgt_oob_d = 1'b0;
    if (edge_q[3]) begin
      tgt_oob_d = (py_q == 6'd0);
      tgt_y_d   = py_q - 6'd1;
    end else if (edge_q[2]) begin
      tgt_oob_d = (py_q == 6'(GRID_H-1));
      tgt_y_d   = py_q + 6'd1;
    end else if (edge_q[1]) begin
      tgt_oob_d = (px_q == 6'd0);
      tgt_x_d   = px_q - 6'd1;
    end else if (edge_q[0]) begin
      tgt_oob_d = (px_q == 6'(GRID_W-1));
      tgt_x_d   = px_q + 6'd1;
    end
  end

  // Out-of-range targets short-circuit before the wall lookup matters.
  assign w_idx     = c_IDX_W'(ty_q) * c_IDX_W'(GRID_W) + c_IDX_W'(tx_q);
  assign w_blocked = toob_q || i_Maze[w_idx];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      maze_state_q <= 2'b00;
      px_q         <= 6'(START_X);
      py_q         <= 6'(START_Y);
      tx_q         <= '0;
      ty_q         <= '0;
      toob_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MAZE_STEP_COUNT_EN
      step_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (edge_q[4]) begin
        px_q <= 6'(START_X);
        py_q <= 6'(START_Y);
`ifdef MAZE_STEP_COUNT_EN
        step_q <= '0;
`endif
        if (i_Maze[c_START_IDX]) begin
          state_q      <= ST_FAULT;
          maze_state_q <= 2'b11;
        end else begin
          state_q      <= ST_WAIT;
          maze_state_q <= 2'b01;
        end
      end else begin
        case (state_q)
          ST_WAIT: begin
            if (w_dir_req) begin
              tx_q    <= tgt_x_d;
              ty_q    <= tgt_y_d;
              toob_q  <= tgt_oob_d;
              state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            state_q <= ST_WAIT;
            if (!w_blocked) begin
              px_q   <= tx_q;
              py_q   <= ty_q;
              done_q <= 1'b1;
`ifdef MAZE_STEP_COUNT_EN
              if (step_q != 16'hFFFF) step_q <= step_q + 16'd1;
`endif
              if ((tx_q == 6'(GOAL_X)) && (ty_q == 6'(GOAL_Y))) begin
                state_q      <= ST_WON;
                maze_state_q <= 2'b10;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_Player_X  = px_q;
  assign o_Player_Y  = py_q;
  assign o_MazeState = maze_state_q;
  assign o_Move_Done = done_q;
`ifdef MAZE_STEP_COUNT_EN
  assign o_Step_Count = step_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maze_player_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_maze_player_ctrl: directed bench for maze_player_ctrl (default grid).    |
// | Step-count checks compile in with MAZE_STEP_COUNT_EN.        Rev 1.0        |
// +----------------------------------------------------------------------------+
module tb_maze_player_ctrl;

  localparam int W = 60;
  localparam int H = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           start, up, down, left, right;
  logic [W*H-1:0] maze;
  logic [5:0]     px, py;
  logic [1:0]     ms;
  logic           done;
`ifdef MAZE_STEP_COUNT_EN
  logic [15:0]    steps;
`endif

  int checks = 0;
  int errors = 0;
  int win_k, win_done, win_first, win_state;
  int total;
  int reached;

  always #5 clk = ~clk;

  maze_player_ctrl dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Start     (start),
    .i_Up        (up),
    .i_Down      (down),
    .i_Left      (left),
    .i_Right     (right),
    .i_Maze      (maze),
    .o_Player_X  (px),
    .o_Player_Y  (py),
    .o_MazeState (ms),
    .o_Move_Done (done)
`ifdef MAZE_STEP_COUNT_EN
    ,
    .o_Step_Count(steps)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    win_k++;
    if (done === 1'b1) begin
      win_done++;
      if (win_first < 0) begin
        win_first = win_k;
        win_state = int'(ms);
      end
    end
  endtask

  task automatic win_open();
    win_k = 0;
    win_done = 0;
    win_first = -1;
    win_state = -1;
  endtask

  // m = {Up, Down, Left, Right}
  task automatic press(input logic [3:0] m);
    win_open();
    {up, down, left, right} = m;
    tick();
    {up, down, left, right} = 4'b0000;
    repeat (7) tick();
  endtask

  task automatic start_pulse();
    win_open();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    rst = 1'b1;
    {start, up, down, left, right} = 5'b0;
    maze = '0;
    repeat (3) tick();
    chk("rst_state", ms, 2'd0);
    chk("rst_x", px, 6'd1);
    chk("rst_y", py, 6'd1);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (4) tick();

    press(4'b0001);
    chk("idle_dir_done", win_done, 0);
    chk("idle_dir_state", ms, 2'd0);
    chk("idle_dir_x", px, 6'd1);

    // Start held through reset release must not start the game
    start = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("held_start_state", ms, 2'd0);
    start = 1'b0;
    repeat (4) tick();

    reached = 0;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) start = 1'b0;
      if (ms === 2'd1) reached = 1;
    end
    chk("start_within4", reached, 1);
    chk("start_x", px, 6'd1);
    chk("start_y", py, 6'd1);
    repeat (4) tick();

    // Right held 100 cycles: one move, committed 5 edges after assertion
    win_open();
    right = 1'b1;
    repeat (100) tick();
    right = 1'b0;
    repeat (6) tick();
    chk("hold_right_moves", win_done, 1);
    chk("hold_right_latency", win_first, 5);
    chk("hold_right_x", px, 6'd2);
    chk("hold_right_y", py, 6'd1);

    press(4'b0010);
    chk("left_back_x", px, 6'd1);
    repeat (4) press(4'b0100);
    chk("down4_y", py, 6'd5);
    press(4'b0010);
    chk("left_to0_done", win_done, 1);
    chk("left_to0_x", px, 6'd0);
    press(4'b0010);
    chk("left_edge_done", win_done, 0);
    chk("left_edge_x", px, 6'd0);
    chk("left_edge_y", py, 6'd5);

    start_pulse();
    chk("restart_x", px, 6'd1);
    chk("restart_y", py, 6'd1);
    maze[2*W+1] = 1'b1;
    press(4'b0100);
    chk("wall_done", win_done, 0);
    chk("wall_y", py, 6'd1);
    maze[2*W+1] = 1'b0;

    press(4'b1001);
    chk("up_right_done", win_done, 1);
    chk("up_right_x", px, 6'd1);
    chk("up_right_y", py, 6'd0);
    press(4'b1000);
    chk("up_edge_done", win_done, 0);
    chk("up_edge_y", py, 6'd0);
    press(4'b0100);
    chk("down_back_y", py, 6'd1);

    // Down edge lands one cycle after the Up edge, i.e. while in CHECK
    win_open();
    up = 1'b1;
    tick();
    up = 1'b0;
    down = 1'b1;
    tick();
    down = 1'b0;
    repeat (8) tick();
    chk("check_drop_done", win_done, 1);
    chk("check_drop_y", py, 6'd0);
    press(4'b0100);
    chk("down_again_y", py, 6'd1);

    start_pulse();
    total = 0;
    for (int i = 0; i < 3; i++) begin
      press(4'b0001);
      total += win_done;
    end
`ifdef MAZE_STEP_COUNT_EN
    chk("step_count3", steps, 16'd3);
`endif
    for (int i = 3; i < 57; i++) begin
      press(4'b0001);
      total += win_done;
    end
    chk("walk_right_moves", total, 57);
    chk("walk_right_x", px, 6'd58);
    chk("walk_right_state", ms, 2'd1);
    for (int i = 0; i < 37; i++) begin
      press(4'b0100);
      total += win_done;
    end
    chk("won_state_at_commit", win_state, 2);
    chk("won_moves", total, 94);
    chk("won_x", px, 6'd58);
    chk("won_y", py, 6'd38);
    chk("won_state", ms, 2'd2);
`ifdef MAZE_STEP_COUNT_EN
    chk("step_count94", steps, 16'd94);
`endif
    press(4'b0010);
    chk("won_ignore_done", win_done, 0);
    chk("won_ignore_x", px, 6'd58);
    chk("won_ignore_state", ms, 2'd2);

    start_pulse();
    chk("won_restart_state", ms, 2'd1);
    chk("won_restart_x", px, 6'd1);
    chk("won_restart_y", py, 6'd1);
`ifdef MAZE_STEP_COUNT_EN
    chk("step_cleared", steps, 16'd0);
`endif

    maze[1*W+1] = 1'b1;
    start_pulse();
    chk("fault_state", ms, 2'd3);
    maze[1*W+1] = 1'b0;
    press(4'b0001);
    chk("fault_ignore_done", win_done, 0);
    chk("fault_ignore_state", ms, 2'd3);

    start_pulse();
    chk("fault_restart_state", ms, 2'd1);

    // Reset while the Right target is being checked
    win_open();
    right = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    right = 1'b0;
    tick();
    chk("rst_check_state", ms, 2'd0);
    chk("rst_check_x", px, 6'd1);
    chk("rst_check_y", py, 6'd1);
    chk("rst_check_done", done, 1'b0);
    rst = 1'b0;
    repeat (8) tick();
    chk("rst_check_no_move", win_done, 0);
    chk("rst_check_idle", ms, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
